// File: rtl/gpo_seq_pkg.sv
// Shared constants for the GPO pattern sequencer: register map, CTRL/STAT bit positions, FSM states.
package gpo_seq_pkg;
  localparam logic [4:0] A_CTRL   = 5'd0;
  localparam logic [4:0] A_STAT   = 5'd1;
  localparam logic [4:0] A_DIRECT = 5'd2;
  localparam logic [4:0] A_WPTR   = 5'd3;
  localparam logic [4:0] A_TVAL   = 5'd4;
  localparam logic [4:0] A_TDUR   = 5'd5;
  localparam logic [4:0] A_LEN    = 5'd6;

  localparam int C_START = 0;
  localparam int C_STOP  = 1;
  localparam int C_LOOP  = 2;
  localparam int C_IE    = 3;

  localparam int S_BUSY = 0;
  localparam int S_DONE = 1;
  localparam int S_IDX  = 16;

  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/gpo_seq_table.sv
// Pattern table: DEPTH entries of (value, duration), one sync write port, one async read port.
module gpo_seq_table #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int DW    = 24,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          val_we_i,
  input  logic          dur_we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wval_i,
  input  logic [DW-1:0] wdur_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rval_o,
  output logic [DW-1:0] rdur_o
);
  logic [W-1:0]  val_q [DEPTH];
  logic [DW-1:0] dur_q [DEPTH];

  // Contents are deliberately not reset; software loads them before use.
  always_ff @(posedge clk) begin
    if (val_we_i) val_q[waddr_i] <= wval_i;
    if (dur_we_i) dur_q[waddr_i] <= wdur_i;
  end

  assign rval_o = val_q[raddr_i];
  assign rdur_o = dur_q[raddr_i];
endmodule

// File: rtl/gpo_seq_core.sv
// MMIO slot core sequencing a W-bit output from a (value, duration) table.
// Optional done interrupt enabled by defining GPO_SEQ_IRQ_EN.
module gpo_seq_core
  import gpo_seq_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int DW    = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cs,
  input  logic         read,
  input  logic         write,
  input  logic [4:0]   addr,
  input  logic [31:0]  wr_data,
  output logic [31:0]  rd_data,
  output logic [W-1:0] dout
`ifdef GPO_SEQ_IRQ_EN
  ,
  output logic         irq
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

  state_t        state_q;
  logic [W-1:0]  dout_q;
  logic [AW-1:0] idx_q, wptr_q;
  logic [DW-1:0] cnt_q;
  logic [AW:0]   len_q;
  logic          loop_q, done_q;
`ifdef GPO_SEQ_IRQ_EN
  logic          ie_q;
`endif

  logic wr, wr_ctrl, wr_stat, wr_direct, wr_wptr, wr_tval, wr_tdur, wr_len;
  logic start, stop, last;
  logic [AW:0]   len_in, len_d, idx_nx;
  logic [AW-1:0] ld_idx;
  logic [W-1:0]  rval;
  logic [DW-1:0] rdur, ld_cnt;
  logic          unused_ok;

  assign wr        = cs && write;
  assign wr_ctrl   = wr && (addr == A_CTRL);
  assign wr_stat   = wr && (addr == A_STAT);
  assign wr_direct = wr && (addr == A_DIRECT);
  assign wr_wptr   = wr && (addr == A_WPTR);
  assign wr_tval   = wr && (addr == A_TVAL);
  assign wr_tdur   = wr && (addr == A_TDUR);
  assign wr_len    = wr && (addr == A_LEN);
  assign stop      = wr_ctrl && wr_data[C_STOP];
  assign start     = wr_ctrl && wr_data[C_START] && !wr_data[C_STOP];
  assign unused_ok = ^{read, wr_data};

  assign len_in = wr_data[AW:0];
  assign len_d  = (len_in > LEN_MAX) ? LEN_MAX : len_in;
  assign idx_nx = {1'b0, idx_q} + {{AW{1'b0}}, 1'b1};
  // Compared against the live LEN so a shortened table ends the sequence at the next entry boundary.
  assign last   = (idx_nx >= len_q);

  // Read address is the entry about to be loaded, so its value/duration are sampled in the loading cycle.
  always_comb begin
    ld_idx = '0;
    if (state_q == RUN && !start && !last) ld_idx = idx_nx[AW-1:0];
  end
  assign ld_cnt = (rdur == '0) ? '0 : rdur - DW'(1);

  gpo_seq_table #(.W(W), .DEPTH(DEPTH), .DW(DW)) u_table (
    .clk      (clk),
    .val_we_i (wr_tval),
    .dur_we_i (wr_tdur),
    .waddr_i  (wptr_q),
    .wval_i   (wr_data[W-1:0]),
    .wdur_i   (wr_data[DW-1:0]),
    .raddr_i  (ld_idx),
    .rval_o   (rval),
    .rdur_o   (rdur)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      dout_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      wptr_q  <= '0;
      len_q   <= '0;
      loop_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef GPO_SEQ_IRQ_EN
      ie_q    <= 1'b0;
`endif
    end else begin
      if (wr_ctrl) loop_q <= wr_data[C_LOOP];
`ifdef GPO_SEQ_IRQ_EN
      if (wr_ctrl) ie_q <= wr_data[C_IE];
`endif
      if (wr_wptr)      wptr_q <= wr_data[AW-1:0];
      else if (wr_tdur) wptr_q <= wptr_q + AW'(1);
      if (wr_len) len_q <= len_d;
      if (wr_stat && wr_data[S_DONE]) done_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (start && len_q != '0) begin
            idx_q   <= ld_idx;
            dout_q  <= rval;
            cnt_q   <= ld_cnt;
            done_q  <= 1'b0;
            state_q <= RUN;
          end else if (wr_direct) begin
            dout_q <= wr_data[W-1:0];
          end
        end
        RUN: begin
          if (stop) begin
            state_q <= IDLE;
          end else if (start) begin
            idx_q  <= ld_idx;
            dout_q <= rval;
            cnt_q  <= ld_cnt;
            done_q <= 1'b0;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - DW'(1);
          end else if (!last || loop_q) begin
            idx_q  <= ld_idx;
            dout_q <= rval;
            cnt_q  <= ld_cnt;
          end else begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dout = dout_q;
`ifdef GPO_SEQ_IRQ_EN
  assign irq = done_q && ie_q;
`endif

  always_comb begin
    rd_data = '0;
    case (addr)
      A_CTRL: begin
        rd_data[C_LOOP] = loop_q;
`ifdef GPO_SEQ_IRQ_EN
        rd_data[C_IE] = ie_q;
`endif
      end
      A_STAT: begin
        rd_data[S_BUSY]          = (state_q == RUN);
        rd_data[S_DONE]          = done_q;
        rd_data[S_IDX+7:S_IDX]   = 8'(idx_q);
      end
      A_DIRECT: rd_data[W-1:0]  = dout_q;
      A_WPTR:   rd_data[AW-1:0] = wptr_q;
      A_LEN:    rd_data[AW:0]   = len_q;
      default:  rd_data = '0;
    endcase
  end
endmodule

// File: tb/tb_gpo_seq_core.sv
// Randomized + directed bench for gpo_seq_core against a timeline model of the pattern table.
module tb_gpo_seq_core;
  logic        clk = 1'b0;
  logic        reset, cs, read, write;
  logic [4:0]  addr;
  logic [31:0] wr_data, rd_data;
  logic [7:0]  dout;
`ifdef GPO_SEQ_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int failures = 0;

  int mv [16];
  int md [16];
  int mlen = 0;
  bit mloop = 0;

  gpo_seq_core dut (
    .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .dout(dout)
`ifdef GPO_SEQ_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the write is captured at the next posedge, returns at the following negedge.
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cs = 1; write = 1; addr = a; wr_data = d;
    @(negedge clk);
    cs = 0; write = 0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rd_data;
  endtask

  function automatic int eff(int k);
    return (md[k] == 0) ? 1 : md[k];
  endfunction

  function automatic int period();
    int p = 0;
    for (int k = 0; k < mlen; k++) p += eff(k);
    return p;
  endfunction

  // Entry active t cycles after the start write (t=0 is the first cycle of entry 0).
  function automatic int exp_entry(int t);
    int p = period();
    int tt;
    if (!mloop && t >= p) return mlen - 1;
    tt = t % p;
    for (int k = 0; k < mlen; k++) begin
      if (tt < eff(k)) return k;
      tt -= eff(k);
    end
    return 0;
  endfunction

  function automatic bit exp_busy(int t);
    return mloop || (t < period());
  endfunction

  task automatic run_check(input int t0, input int n, input string tag);
    logic [31:0] s;
    for (int t = t0; t < t0 + n; t++) begin
      rd(5'd1, s);
      chk({tag, "_dout"}, 32'(dout), 32'(mv[exp_entry(t)]));
      chk({tag, "_busy"}, 32'(s[0]), 32'(exp_busy(t)));
      if (exp_busy(t)) chk({tag, "_idx"}, 32'(s[23:16]), 32'(exp_entry(t)));
      @(negedge clk);
    end
  endtask

  task automatic load(input int n);
    wr(5'd3, 32'd0);
    for (int k = 0; k < n; k++) begin
      wr(5'd4, 32'(mv[k]));
      wr(5'd5, 32'(md[k]));
    end
    wr(5'd6, 32'(n));
    mlen = (n > 16) ? 16 : n;
  endtask

  task automatic start(input bit lp, input bit ie);
    wr(5'd0, {28'd0, ie, lp, 2'b01});
    mloop = lp;
  endtask

  initial begin
    logic [31:0] s;
    int p, n, hold;
    reset = 1; cs = 0; read = 0; write = 0; addr = 0; wr_data = 0;
    repeat (3) @(negedge clk);
    reset = 0;

    // reset state
    chk("rst_dout", 32'(dout), 32'h0);
    rd(5'd1, s); chk("rst_stat", s, 32'h0);
    rd(5'd6, s); chk("rst_len", s, 32'h0);
    rd(5'd3, s); chk("rst_wptr", s, 32'h0);
    rd(5'd0, s); chk("rst_ctrl", s, 32'h0);
    @(negedge clk);
    wr(5'd2, 32'hA5);
    chk("direct_dout", 32'(dout), 32'hA5);
    rd(5'd2, s); chk("direct_rd", s, 32'hA5);
    rd(5'd7, s); chk("bad_addr_rd", s, 32'h0);
    @(negedge clk);

    // LEN saturation and WPTR wrap
    wr(5'd6, 32'd31); rd(5'd6, s); chk("len_sat31", s, 32'd16); @(negedge clk);
    wr(5'd6, 32'h25); rd(5'd6, s); chk("len_low5", s, 32'd5);   @(negedge clk);
    wr(5'd6, 32'd17); rd(5'd6, s); chk("len_sat17", s, 32'd16); @(negedge clk);
    wr(5'd3, 32'd15); wr(5'd5, 32'd1); md[15] = 1;
    rd(5'd3, s); chk("wptr_wrap", s, 32'd0); @(negedge clk);

    // one-shot
    mv[0] = 8'h01; md[0] = 3; mv[1] = 8'h02; md[1] = 1; mv[2] = 8'h04; md[2] = 0;
    load(3);
    rd(5'd3, s); chk("wptr_inc", s, 32'd3); @(negedge clk);
    start(0, 0);
    run_check(0, 8, "oneshot");
    rd(5'd1, s); chk("oneshot_stat", s & 32'h3, 32'h2);
    chk("oneshot_hold", 32'(dout), 32'h04);
    @(negedge clk);

    // loop then stop mid-entry; done cleared by start
    start(1, 0);
    rd(5'd0, s); chk("ctrl_loop_rd", s, 32'h4); @(negedge clk);
    run_check(1, 11, "loop");
    hold = mv[exp_entry(12)];
    wr(5'd0, 32'h2);
    rd(5'd1, s); chk("stop_stat", s & 32'h3, 32'h0);
    chk("stop_hold", 32'(dout), 32'(hold));
    @(negedge clk);
    chk("stop_hold2", 32'(dout), 32'(hold));

    // start with LEN=0 ignored
    wr(5'd6, 32'd0);
    start(0, 0);
    rd(5'd1, s); chk("len0_busy", 32'(s[0]), 32'h0);
    chk("len0_dout", 32'(dout), 32'(hold));
    @(negedge clk);
    // start+stop in one write from IDLE and from RUN
    wr(5'd6, 32'd3); mlen = 3;
    wr(5'd0, 32'h3);
    rd(5'd1, s); chk("ss_idle_busy", 32'(s[0]), 32'h0); @(negedge clk);
    start(0, 0);
    wr(5'd0, 32'h3);
    rd(5'd1, s); chk("ss_run_busy", 32'(s[0]), 32'h0); @(negedge clk);

    // DIRECT write during RUN ignored
    start(0, 0);
    wr(5'd2, 32'hFF);
    run_check(1, 6, "direct_run");

    // restart at idx 2
    start(0, 0);
    run_check(0, 4, "pre_restart");
    rd(5'd1, s); chk("restart_idx", 32'(s[23:16]), 32'd2); @(negedge clk);
    start(0, 0);
    run_check(0, 6, "restart");

    // reset mid-RUN
    start(1, 0);
    run_check(0, 2, "pre_reset");
    reset = 1; @(negedge clk); reset = 0;
    mlen = 0; mloop = 0;
    chk("midrst_dout", 32'(dout), 32'h0);
    rd(5'd1, s); chk("midrst_stat", s, 32'h0);
    rd(5'd6, s); chk("midrst_len", s, 32'h0);
    @(negedge clk);

`ifdef GPO_SEQ_IRQ_EN
    load(3);
    start(0, 1);
    rd(5'd0, s); chk("ctrl_ie_rd", s, 32'h8);
    chk("irq_low", 32'(irq), 32'h0);
    @(negedge clk);
    run_check(1, 5, "irq_run");
    chk("irq_high", 32'(irq), 32'h1);
    wr(5'd1, 32'h2);
    chk("irq_clr", 32'(irq), 32'h0);
    rd(5'd1, s); chk("irq_done_clr", 32'(s[1]), 32'h0);
    @(negedge clk);
`endif

    // randomized tables
    for (int it = 0; it < 20; it++) begin
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        mv[k] = $urandom_range(0, 255);
        md[k] = $urandom_range(0, 4);
      end
      load(n);
      start(1'($urandom_range(0, 1)), 0);
      p = period();
      if (!mloop) begin
        run_check(0, p + 2, "rnd_os");
        rd(5'd1, s); chk("rnd_done", s & 32'h3, 32'h2);
        @(negedge clk);
      end else begin
        int m = 2 * p + $urandom_range(0, p);
        run_check(0, m, "rnd_lp");
        hold = mv[exp_entry(m)];
        wr(5'd0, 32'h2);
        rd(5'd1, s); chk("rnd_stop", s & 32'h3, 32'h0);
        chk("rnd_hold", 32'(dout), 32'(hold));
        @(negedge clk);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
